// File: rtl/j2fam_bus_pkg.sv
// Shared bus definitions: DMA controller states and default bus addresses.
package j2fam_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HALT,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] OAM_DMA_TRIGGER = 16'h4014;
  localparam logic [15:0] OAM_DATA_PORT   = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA bus-sharing controller. In IDLE the CPU talks straight to memory.
// A completed CPU write to the trigger address makes the controller take the
// bus, stall the CPU, and copy one page to the OAM data port before handing
// the bus back.
module oam_dma
  import j2fam_bus_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDRESS  = OAM_DMA_TRIGGER,
  parameter logic [15:0] OAM_DATA_ADDRESS = OAM_DATA_PORT,
  parameter int          TRANSFER_LENGTH  = 256
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [15:0] cpu_address_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        cpu_bus_read_i,
  input  logic        cpu_bus_write_i,
  output logic [7:0]  cpu_data_o,
  output logic        cpu_data_valid_o,
  output logic [15:0] mem_address_o,
  output logic [7:0]  mem_data_o,
  output logic        mem_bus_read_o,
  output logic        mem_bus_write_o,
  input  logic [7:0]  mem_data_i,
  input  logic        mem_data_valid_i,
  output logic        dma_active_o
);

  // Index of the final byte; the transfer ends after writing this one.
  localparam logic [7:0] LAST_INDEX = 8'(TRANSFER_LENGTH - 1);

  dma_state_t r_state;
  dma_state_t w_next_state;
  logic [7:0] r_page;
  logic [7:0] r_count;
  logic [7:0] r_hold;
  logic       w_trigger;

  // A trigger is only accepted once the CPU's write has actually completed.
  assign w_trigger = cpu_bus_write_i && (cpu_address_i == TRIGGER_ADDRESS)
                     && mem_data_valid_i;

  assign dma_active_o = (r_state != IDLE);

  // State register plus the page/byte-index/holding registers of the copy loop.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_page  <= 8'h00;
      r_count <= 8'h00;
      r_hold  <= 8'h00;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_page  <= cpu_data_i;
            r_count <= 8'h00;
          end
        end
        READ: begin
          if (mem_data_valid_i) begin
            r_hold <= mem_data_i;
          end
        end
        WRITE: begin
          if (mem_data_valid_i && (r_count != LAST_INDEX)) begin
            r_count <= r_count + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Bus multiplexer and next-state logic, keyed on who owns the bus.
  always_comb begin
    w_next_state     = r_state;
    cpu_data_o       = mem_data_i;
    cpu_data_valid_o = 1'b0;
    mem_address_o    = 16'h0000;
    mem_data_o       = 8'h00;
    mem_bus_read_o   = 1'b0;
    mem_bus_write_o  = 1'b0;
    case (r_state)
      IDLE: begin
        mem_address_o    = cpu_address_i;
        mem_data_o       = cpu_data_i;
        mem_bus_read_o   = cpu_bus_read_i;
        mem_bus_write_o  = cpu_bus_write_i;
        cpu_data_valid_o = mem_data_valid_i;
        if (w_trigger) begin
          w_next_state = HALT;
        end
      end
      HALT: begin
        w_next_state = READ;
      end
      READ: begin
        mem_address_o  = {r_page, r_count};
        mem_bus_read_o = 1'b1;
        if (mem_data_valid_i) begin
          w_next_state = WRITE;
        end
      end
      WRITE: begin
        mem_address_o   = OAM_DATA_ADDRESS;
        mem_data_o      = r_hold;
        mem_bus_write_o = 1'b1;
        if (mem_data_valid_i) begin
          w_next_state = (r_count == LAST_INDEX) ? IDLE : READ;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule
